fifo_request_arbiter: RTL

FIFO_REQUEST_ARBITER -- requirements
Module: fifo_request_arbiter

---
 rtl/fifo_request_arbiter.sv | 117 +++++++++++
 1 files changed

// File: rtl/fifo_request_arbiter.sv
// fifo_request_arbiter: round-robin arbiter that funnels several
// valid/ack requesters into the single write port of a fifo_queue.
module fifo_request_arbiter #(
   parameter int NUM_REQUESTERS             = 4,
   parameter int NUM_REQUESTERS_LOG2        = 2,
   parameter int SINGLE_ENTRY_WIDTH_IN_BITS = 32
) (
   input  logic                                                  clk_in,
   input  logic                                                  reset_in,
   input  logic [NUM_REQUESTERS*SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_flatted_in,
   input  logic [NUM_REQUESTERS-1:0]                             request_valid_flatted_in,
   output logic [NUM_REQUESTERS-1:0]                             issue_ack_out,
   input  logic                                                  fifo_is_full_in,
   output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0]                 request_out,
   output logic                                                  request_valid_out,
   input  logic                                                  issue_ack_in,
   output logic [NUM_REQUESTERS_LOG2-1:0]                        grant_index_out
);

   localparam int N = NUM_REQUESTERS;
   localparam int L = NUM_REQUESTERS_LOG2;
   localparam int W = SINGLE_ENTRY_WIDTH_IN_BITS;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      ACK   = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic           valid_q, valid_d;
   logic [W-1:0]   req_q, req_d;
   logic [N-1:0]   ack_q, ack_d;
   logic [L-1:0]   gidx_q, gidx_d;
   logic [L-1:0]   last_q, last_d;

   logic           pick_found;
   logic [L-1:0]   pick_idx;
   logic [W-1:0]   pick_payload;
   int             idx;

   // Round-robin search starting just after the last acked requester.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      idx        = 0;
      for (int k = 1; k <= N; k++) begin
         idx = (int'(last_q) + k) % N;
         if (!pick_found && request_valid_flatted_in[idx]) begin
            pick_found = 1'b1;
            pick_idx   = idx[L-1:0];
         end
      end
   end

   assign pick_payload = request_flatted_in[int'(pick_idx)*W +: W];

   // Next-state and registered-output logic for the IDLE/GRANT/ACK cycle.
   always_comb begin
      state_d = state_q;
      valid_d = valid_q;
      req_d   = req_q;
      gidx_d  = gidx_q;
      last_d  = last_q;
      ack_d   = '0;
      unique case (state_q)
         IDLE: begin
            if (!fifo_is_full_in && pick_found) begin
               state_d = GRANT;
               valid_d = 1'b1;
               req_d   = pick_payload;
               gidx_d  = pick_idx;
            end
         end
         GRANT: begin
            if (issue_ack_in) begin
               state_d = ACK;
               valid_d = 1'b0;
               ack_d   = {{(N-1){1'b0}}, 1'b1} << gidx_q;
               last_d  = gidx_q;
            end
         end
         ACK: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
         end
      endcase
   end

   // State and output registers; reset gives requester 0 first priority.
   always_ff @(posedge clk_in or negedge reset_in) begin
      if (!reset_in) begin
         state_q <= IDLE;
         valid_q <= 1'b0;
         req_q   <= '0;
         ack_q   <= '0;
         gidx_q  <= '0;
         last_q  <= L'(N-1);
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         req_q   <= req_d;
         ack_q   <= ack_d;
         gidx_q  <= gidx_d;
         last_q  <= last_d;
      end
   end

   assign request_valid_out = valid_q;
   assign request_out       = req_q;
   assign issue_ack_out     = ack_q;
   assign grant_index_out   = gidx_q;

endmodule
